// File: rtl/ibex_asconp_iter_pkg.sv
// Ascon permutation shared types: state words, FSM encoding, round constant, S-box and rotations.
// Pure definitions, no timing; imported by the round datapath and the iterating controller.
package ibex_ascon_defines;

    typedef struct packed {
        logic [63:0] x0;
        logic [63:0] x1;
        logic [63:0] x2;
        logic [63:0] x3;
        logic [63:0] x4;
    } ascon_state_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } fsm_e;

    localparam int unsigned ROT_X0_A = 19;
    localparam int unsigned ROT_X0_B = 28;
    localparam int unsigned ROT_X1_A = 61;
    localparam int unsigned ROT_X1_B = 39;
    localparam int unsigned ROT_X2_A = 1;
    localparam int unsigned ROT_X2_B = 6;
    localparam int unsigned ROT_X3_A = 10;
    localparam int unsigned ROT_X3_B = 17;
    localparam int unsigned ROT_X4_A = 7;
    localparam int unsigned ROT_X4_B = 41;

    function automatic logic [7:0] round_const(input logic [3:0] r);
        return {4'd15 - r, r};
    endfunction

    function automatic logic [63:0] rotr(input logic [63:0] x, input int unsigned amt);
        return (x >> amt) | (x << (64 - amt));
    endfunction

    function automatic logic [63:0] diffuse(input logic [63:0] x, input int unsigned a,
                                            input int unsigned b);
        return x ^ rotr(x, a) ^ rotr(x, b);
    endfunction

    // Slice index is {x0,x1,x2,x3,x4} with x0 as the MSB.
    function automatic logic [4:0] sbox(input logic [4:0] v);
        logic [4:0] o;
        case (v)
            5'd0:  o = 5'h04;  5'd1:  o = 5'h0b;  5'd2:  o = 5'h1f;  5'd3:  o = 5'h14;
            5'd4:  o = 5'h1a;  5'd5:  o = 5'h15;  5'd6:  o = 5'h09;  5'd7:  o = 5'h02;
            5'd8:  o = 5'h1b;  5'd9:  o = 5'h05;  5'd10: o = 5'h08;  5'd11: o = 5'h12;
            5'd12: o = 5'h1d;  5'd13: o = 5'h03;  5'd14: o = 5'h06;  5'd15: o = 5'h1c;
            5'd16: o = 5'h1e;  5'd17: o = 5'h13;  5'd18: o = 5'h07;  5'd19: o = 5'h0e;
            5'd20: o = 5'h00;  5'd21: o = 5'h0d;  5'd22: o = 5'h11;  5'd23: o = 5'h18;
            5'd24: o = 5'h10;  5'd25: o = 5'h0c;  5'd26: o = 5'h01;  5'd27: o = 5'h19;
            5'd28: o = 5'h16;  5'd29: o = 5'h0a;  5'd30: o = 5'h0f;  default: o = 5'h17;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/ibex_asconp_round.sv
// One Ascon round: constant addition, S-box layer, linear diffusion.
// Purely combinational (zero latency), no flow control.
module ibex_asconp_round
    import ibex_ascon_defines::*;
(
    input  ascon_state_t state,
    input  logic [3:0]   round_idx,
    output ascon_state_t result
);

    logic [63:0] x2_c;
    logic [63:0] s0, s1, s2, s3, s4;

    assign x2_c = state.x2 ^ {56'd0, round_const(round_idx)};

    for (genvar i = 0; i < 64; i++) begin : g_slice
        assign {s0[i], s1[i], s2[i], s3[i], s4[i]} =
            sbox({state.x0[i], state.x1[i], x2_c[i], state.x3[i], state.x4[i]});
    end

    always_comb begin
        result    = '0;
        result.x0 = diffuse(s0, ROT_X0_A, ROT_X0_B);
        result.x1 = diffuse(s1, ROT_X1_A, ROT_X1_B);
        result.x2 = diffuse(s2, ROT_X2_A, ROT_X2_B);
        result.x3 = diffuse(s3, ROT_X3_A, ROT_X3_B);
        result.x4 = diffuse(s4, ROT_X4_A, ROT_X4_B);
    end

endmodule

// File: rtl/ibex_asconp_iter.sv
// Iterative Ascon-p: RoundsPerCycle rounds per BUSY cycle; valid_o at k+ceil(n/RoundsPerCycle)+1.
// ready_o is low only while BUSY; abort_i drops the operation and returns to IDLE.
module ibex_asconp_iter
    import ibex_ascon_defines::*;
#(
    parameter int unsigned RoundsPerCycle = 1,
    parameter int unsigned MaxRounds      = 12
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         req_i,
    output logic         ready_o,
    input  logic [3:0]   rounds_i,
    input  ascon_state_t state_i,
    input  logic         abort_i,
    output ascon_state_t state_o,
    output logic         valid_o
);

    localparam logic [3:0] Rpc  = 4'(RoundsPerCycle);
    localparam logic [3:0] MaxN = 4'(MaxRounds);

    fsm_e         fsm_q;
    logic [3:0]   rem_q;
    logic [3:0]   idx_q;
    ascon_state_t state_q;
    logic         valid_q;
    logic         ready_q;

    logic         accept;
    logic [3:0]   n_clamped;
    logic [3:0]   r0;
    logic [3:0]   step;
    logic [3:0]   rem_next;

    ascon_state_t chain [RoundsPerCycle+1];
    ascon_state_t rnd   [RoundsPerCycle];

    assign accept    = req_i & ready_q & ~abort_i;
    assign n_clamped = (rounds_i > MaxN) ? MaxN : rounds_i;
    assign r0        = 4'd12 - n_clamped;
    assign step      = (rem_q > Rpc) ? Rpc : rem_q;
    assign rem_next  = rem_q - step;

    // Stages past the remaining count pass the state through untouched.
    assign chain[0] = state_q;
    for (genvar j = 0; j < RoundsPerCycle; j++) begin : g_round
        ibex_asconp_round u_round (
            .state     (chain[j]),
            .round_idx (idx_q + 4'(j)),
            .result    (rnd[j])
        );
        assign chain[j+1] = (4'(j) < rem_q) ? rnd[j] : chain[j];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fsm_q   <= IDLE;
            rem_q   <= '0;
            idx_q   <= '0;
            state_q <= '0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
        end else if (abort_i) begin
            fsm_q   <= IDLE;
            rem_q   <= '0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            case (fsm_q)
                IDLE, DONE: begin
                    if (accept) begin
                        state_q <= state_i;
                        rem_q   <= n_clamped;
                        idx_q   <= r0;
                        if (n_clamped == 4'd0) begin
                            fsm_q   <= DONE;
                            valid_q <= 1'b1;
                            ready_q <= 1'b1;
                        end else begin
                            fsm_q   <= BUSY;
                            valid_q <= 1'b0;
                            ready_q <= 1'b0;
                        end
                    end else begin
                        fsm_q   <= IDLE;
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                    end
                end
                BUSY: begin
                    state_q <= chain[RoundsPerCycle];
                    rem_q   <= rem_next;
                    idx_q   <= idx_q + step;
                    if (rem_next == 4'd0) begin
                        fsm_q   <= DONE;
                        valid_q <= 1'b1;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    fsm_q   <= IDLE;
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign state_o = state_q;
    assign valid_o = valid_q;
    assign ready_o = ready_q;

endmodule

// File: tb/tb_ibex_asconp_iter.sv
// Bench for ibex_asconp_iter: one instance with 1 round/cycle, one with 4, checked against a word-level Ascon model.
module tb_ibex_asconp_iter;
    import ibex_ascon_defines::*;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req    [2];
    logic         abort  [2];
    logic [3:0]   rounds [2];
    ascon_state_t st_in  [2];
    ascon_state_t st_out [2];
    logic         ready  [2];
    logic         valid  [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ibex_asconp_iter #(.RoundsPerCycle(1), .MaxRounds(12)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req[0]), .ready_o(ready[0]),
        .rounds_i(rounds[0]), .state_i(st_in[0]), .abort_i(abort[0]),
        .state_o(st_out[0]), .valid_o(valid[0])
    );

    ibex_asconp_iter #(.RoundsPerCycle(4), .MaxRounds(12)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req[1]), .ready_o(ready[1]),
        .rounds_i(rounds[1]), .state_i(st_in[1]), .abort_i(abort[1]),
        .state_o(st_out[1]), .valid_o(valid[1])
    );

    // ---------------- reference model (word-level, bitsliced S-box) ----------------
    function automatic logic [63:0] m_rotr(input logic [63:0] x, input int k);
        return (x >> k) | (x << (64 - k));
    endfunction

    function automatic ascon_state_t model_perm(input ascon_state_t s, input int n);
        logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
        ascon_state_t o;
        int nn;
        nn = (n > 12) ? 12 : n;
        x0 = s.x0; x1 = s.x1; x2 = s.x2; x3 = s.x3; x4 = s.x4;
        for (int r = 12 - nn; r < 12; r++) begin
            x2 = x2 ^ 64'(((15 - r) << 4) | r);
            x0 ^= x4; x4 ^= x3; x2 ^= x1;
            t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
            x0 ^= t1; x1 ^= t2; x2 ^= t3; x3 ^= t4; x4 ^= t0;
            x1 ^= x0; x0 ^= x4; x3 ^= x2; x2 = ~x2;
            x0 = x0 ^ m_rotr(x0, 19) ^ m_rotr(x0, 28);
            x1 = x1 ^ m_rotr(x1, 61) ^ m_rotr(x1, 39);
            x2 = x2 ^ m_rotr(x2, 1)  ^ m_rotr(x2, 6);
            x3 = x3 ^ m_rotr(x3, 10) ^ m_rotr(x3, 17);
            x4 = x4 ^ m_rotr(x4, 7)  ^ m_rotr(x4, 41);
        end
        o.x0 = x0; o.x1 = x1; o.x2 = x2; o.x3 = x3; o.x4 = x4;
        return o;
    endfunction

    function automatic int exp_lat(input int n, input int rpc);
        int nn;
        nn = (n > 12) ? 12 : n;
        return (nn == 0) ? 1 : (nn + rpc - 1) / rpc + 1;
    endfunction

    function automatic ascon_state_t rand_state();
        ascon_state_t s;
        s = {$urandom, $urandom, $urandom, $urandom, $urandom,
             $urandom, $urandom, $urandom, $urandom, $urandom};
        return s;
    endfunction

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [319:0] act, input logic [319:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issues one request on instance u and waits for valid; starts at a negedge.
    task automatic run_op(input int u, input logic [3:0] n, input ascon_state_t s,
                          input bit chained, output int lat, output ascon_state_t res,
                          output int busy_rdy);
        if (!chained) @(negedge clk);
        check($sformatf("ready_before_req u%0d", u), 320'(ready[u]), 320'd1);
        req[u] = 1'b1; rounds[u] = n; st_in[u] = s;
        @(negedge clk);
        req[u] = 1'b0; st_in[u] = rand_state();
        lat = 1; busy_rdy = 0;
        while (valid[u] !== 1'b1 && lat < 40) begin
            if (ready[u] !== 1'b0) busy_rdy++;
            @(negedge clk);
            lat++;
        end
        res = st_out[u];
    endtask

    task automatic do_op(input int u, input logic [3:0] n, input ascon_state_t s,
                         input bit chained, input string name);
        int lat, br;
        ascon_state_t res;
        int rpc;
        rpc = (u == 0) ? 1 : 4;
        run_op(u, n, s, chained, lat, res, br);
        check($sformatf("%s_lat u%0d n%0d", name, u, n), 320'(lat), 320'(exp_lat(int'(n), rpc)));
        check($sformatf("%s_state u%0d n%0d", name, u, n), res, model_perm(s, int'(n)));
        check($sformatf("%s_busy_ready u%0d", name, u), 320'(br), 320'd0);
    endtask

    task automatic count_valid(input int u, input int cycles, output int seen);
        seen = 0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            if (valid[u] === 1'b1) seen++;
        end
    endtask

    typedef struct {
        logic [3:0]   n;
        ascon_state_t s;
        ascon_state_t exp_state;
        int           exp_lat [2];
    } vec_t;

    vec_t vecs [9];

    initial begin
        ascon_state_t r15, held, zero_s, tmp;
        int seen;

        zero_s = '0;
        r15 = rand_state();
        vecs[0].n = 4'd12; vecs[0].s = rand_state();
        vecs[1].n = 4'd6;  vecs[1].s = rand_state();
        vecs[2].n = 4'd8;  vecs[2].s = rand_state();
        vecs[3].n = 4'd0;  vecs[3].s = zero_s;
        vecs[4].n = 4'd15; vecs[4].s = r15;
        vecs[5].n = 4'd12; vecs[5].s = r15;
        vecs[6].n = 4'd1;  vecs[6].s = zero_s;
        vecs[7].n = 4'd3;  vecs[7].s = '1;
        vecs[8].n = 4'd2;  vecs[8].s = rand_state();
        foreach (vecs[i]) begin
            vecs[i].exp_state  = model_perm(vecs[i].s, int'(vecs[i].n));
            vecs[i].exp_lat[0] = exp_lat(int'(vecs[i].n), 1);
            vecs[i].exp_lat[1] = exp_lat(int'(vecs[i].n), 4);
        end

        rst_n = 1'b0;
        for (int u = 0; u < 2; u++) begin
            req[u] = 1'b0; abort[u] = 1'b0; rounds[u] = '0; st_in[u] = '0;
        end
        #12;
        for (int u = 0; u < 2; u++) begin
            check($sformatf("reset_ready u%0d", u), 320'(ready[u]), 320'd1);
            check($sformatf("reset_valid u%0d", u), 320'(valid[u]), 320'd0);
            check($sformatf("reset_state u%0d", u), st_out[u], 320'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        for (int u = 0; u < 2; u++) begin
            // table-driven vectors
            foreach (vecs[i]) begin
                int lat, br;
                ascon_state_t res;
                run_op(u, vecs[i].n, vecs[i].s, 1'b0, lat, res, br);
                check($sformatf("vec%0d_lat u%0d", i, u), 320'(lat), 320'(vecs[i].exp_lat[u]));
                check($sformatf("vec%0d_state u%0d", i, u), res, vecs[i].exp_state);
                check($sformatf("vec%0d_busy_ready u%0d", i, u), 320'(br), 320'd0);
                @(negedge clk);
                check($sformatf("vec%0d_valid_pulse u%0d", i, u), 320'(valid[u]), 320'd0);
                check($sformatf("vec%0d_idle_ready u%0d", i, u), 320'(ready[u]), 320'd1);
                check($sformatf("vec%0d_idle_stable u%0d", i, u), st_out[u], vecs[i].exp_state);
            end

            // randomized operations, some issued back-to-back from DONE
            for (int i = 0; i < 12; i++) begin
                bit ch;
                ch = (i > 0) && ($urandom_range(0, 1) == 1);
                do_op(u, 4'($urandom_range(0, 15)), rand_state(), ch, "rand");
            end

            // req held through DONE: three operations with no idle cycle between them
            @(negedge clk);
            do_op(u, 4'd12, rand_state(), 1'b0, "b2b_first");
            do_op(u, 4'd5, rand_state(), 1'b1, "b2b_second");
            do_op(u, 4'd0, rand_state(), 1'b1, "b2b_third");

            // abort mid-operation together with a new request
            @(negedge clk);
            req[u] = 1'b1; rounds[u] = 4'd12; st_in[u] = rand_state();
            @(negedge clk);
            req[u] = 1'b0;
            repeat (((u == 0) ? 5 : 2) - 1) @(negedge clk);
            abort[u] = 1'b1; req[u] = 1'b1; rounds[u] = 4'd0;
            @(negedge clk);
            abort[u] = 1'b0; req[u] = 1'b0;
            check($sformatf("abort_ready u%0d", u), 320'(ready[u]), 320'd1);
            check($sformatf("abort_valid u%0d", u), 320'(valid[u]), 320'd0);
            held = st_out[u];
            count_valid(u, 20, seen);
            check($sformatf("abort_no_valid u%0d", u), 320'(seen), 320'd0);
            check($sformatf("abort_state_stable u%0d", u), st_out[u], held);

            // req with abort while idle is ignored
            abort[u] = 1'b1; req[u] = 1'b1; rounds[u] = 4'd0; st_in[u] = rand_state();
            @(negedge clk);
            abort[u] = 1'b0; req[u] = 1'b0;
            check($sformatf("idle_abort_req_valid u%0d", u), 320'(valid[u]), 320'd0);
            check($sformatf("idle_abort_req_state u%0d", u), st_out[u], held);

            // reset pulsed mid-BUSY
            req[u] = 1'b1; rounds[u] = 4'd12; tmp = rand_state(); st_in[u] = tmp;
            @(negedge clk);
            req[u] = 1'b0;
            @(negedge clk);
            rst_n = 1'b0;
            #2;
            check($sformatf("rst_busy_state u%0d", u), st_out[u], 320'd0);
            check($sformatf("rst_busy_valid u%0d", u), 320'(valid[u]), 320'd0);
            @(negedge clk);
            rst_n = 1'b1;
            check($sformatf("rst_busy_ready u%0d", u), 320'(ready[u]), 320'd1);
            count_valid(u, 20, seen);
            check($sformatf("rst_busy_no_valid u%0d", u), 320'(seen), 320'd0);
            check($sformatf("rst_busy_state_after u%0d", u), st_out[u], 320'd0);

            // still functional after the reset pulse
            do_op(u, 4'd12, tmp, 1'b0, "post_rst");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
